// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared definitions for the wide_add_seq slice-sequenced adder.
//   SLICE_W  - width of one adder slice
//   state_e  - controller state encoding (2'd3 is illegal and recovers to ST_IDLE)
package wide_add_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wide_add_seq_if.sv
// wide_add_seq_if: operand/result handshake bundle for wide_add_seq.
//   master: in_valid, a, b, c_in, out_ready (and sub when WIDE_ADD_SUB_EN is defined) out;
//           in_ready, out_valid, sum, c_out, busy in.
//   slave : the mirror image, used by wide_add_seq.
// Optional macro: WIDE_ADD_SUB_EN adds the 1-bit `sub` request signal.
interface wide_add_seq_if #(
  parameter int unsigned WORDS = 4
);
  import wide_add_pkg::*;

  localparam int unsigned W = WORDS * SLICE_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
`ifdef WIDE_ADD_SUB_EN
  logic         sub;
`endif

  modport master (
`ifdef WIDE_ADD_SUB_EN
    output sub,
`endif
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  modport slave (
`ifdef WIDE_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );

endinterface

// File: rtl/csa_16.sv
// csa_16: combinational 16-bit carry-select adder.
//   a, b  - 16-bit addends
//   cin   - carry in
//   sum   - 16-bit sum
//   cout  - carry out
module csa_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  always_comb begin
    lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'b0, cin};
    // Upper byte computed for both possible carries, picked by the low carry.
    hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;
    sum = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
    cout = lo[8] ? hi1[8] : hi0[8];
  end

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle WORDS*16-bit adder. One shared csa_16 walks the operand slices
// LSB first, chaining the carry through carry_q. Result is held until the consumer takes it.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - wide_add_seq_if.slave: in_valid/in_ready/a/b/c_in request side,
//          out_valid/out_ready/sum/c_out result side, busy status
// Optional macro: WIDE_ADD_SUB_EN adds bus.sub; when set at acceptance the block computes a-b
// (b slices inverted, initial carry forced to 1, c_out=1 meaning no borrow).
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input logic          clk,
  input logic          rst,
  wide_add_seq_if.slave bus
);

  localparam int unsigned        IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(WORDS - 1);

  state_e                          state_q;
  logic [IDX_W-1:0]                idx_q;
  logic [WORDS-1:0][SLICE_W-1:0]   a_q;
  logic [WORDS-1:0][SLICE_W-1:0]   b_q;
  logic [WORDS-1:0][SLICE_W-1:0]   sum_q;
  logic                            carry_q;
  logic                            c_out_q;
  logic                            sub_q;
  logic                            in_ready_q;
  logic                            out_valid_q;
  logic                            busy_q;

  logic                            sub_in;
  logic [SLICE_W-1:0]              a_sl;
  logic [SLICE_W-1:0]              b_sl;
  logic [SLICE_W-1:0]              s_sl;
  logic                            co_sl;

`ifdef WIDE_ADD_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Slice select; subtraction is a + ~b + 1 with the +1 injected via the initial carry.
  always_comb begin
    a_sl = a_q[idx_q];
    b_sl = b_q[idx_q] ^ {SLICE_W{sub_q}};
  end

  csa_16 u_csa (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (s_sl),
    .cout (co_sl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      sub_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone completes the handshake.
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            sub_q      <= sub_in;
            carry_q    <= sub_in | bus.c_in;
            idx_q      <= '0;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          sum_q[idx_q] <= s_sl;
          carry_q      <= co_sl;
          if (idx_q == IDX_LAST) begin
            idx_q       <= '0;
            c_out_q     <= co_sl;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: directed bench for wide_add_seq with a WORDS=4 and a WORDS=1 instance.
// Expected results come from a full-width arithmetic model and are queued at acceptance.
// Optional macro: WIDE_ADD_SUB_EN enables the subtraction steps.
module tb_wide_add_seq;
  import wide_add_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wide_add_seq_if #(.WORDS(4)) bus4 ();
  wide_add_seq_if #(.WORDS(1)) bus1 ();

  wide_add_seq #(.WORDS(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  wide_add_seq #(.WORDS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [64:0] exp4_q[$];
  logic [16:0] exp1_q[$];

  function automatic logic [64:0] model4(input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sb);
    logic [63:0] bb;
    logic        ci;
    bb = sb ? ~b : b;
    ci = sb ? 1'b1 : cin;
    return {1'b0, a} + {1'b0, bb} + {64'b0, ci};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge in IDLE; acceptance happens on the next posedge.
  task automatic accept4(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic sb, input bit push);
    check("in_ready_idle", bus4.in_ready, 1'b1);
    bus4.a        = a;
    bus4.b        = b;
    bus4.c_in     = cin;
`ifdef WIDE_ADD_SUB_EN
    bus4.sub      = sb;
`endif
    bus4.in_valid = 1'b1;
    if (push) exp4_q.push_back(model4(a, b, cin, sb));
  endtask

  task automatic pop_cmp4();
    logic [64:0] e;
    check("out_valid4", bus4.out_valid, 1'b1);
    if (exp4_q.size() == 0) begin
      check("scoreboard4_nonempty", 64'd0, 64'd1);
    end else begin
      e = exp4_q.pop_front();
      check("sum4", bus4.sum, e[63:0]);
      check("c_out4", bus4.c_out, {63'b0, e[64]});
    end
  endtask

  task automatic await4(input int lat, input bit drop);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (drop) bus4.in_valid = 1'b0;
        check("busy_run4", bus4.busy, 1'b1);
        check("in_ready_run4", bus4.in_ready, 1'b0);
      end
    end while (bus4.out_valid !== 1'b1 && n < 40);
    check("latency4", 64'(n), 64'(lat));
    pop_cmp4();
  endtask

  task automatic handshake4();
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    check("out_valid_after_hs4", bus4.out_valid, 1'b0);
    check("in_ready_after_hs4", bus4.in_ready, 1'b1);
  endtask

  initial begin
    logic [63:0] ra, rb, snap_sum;
    logic        rc, snap_c;
    logic [16:0] e1;
    int          n;

    rst            = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.c_in      = 1'b0;
    bus4.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.c_in      = 1'b0;
    bus1.out_ready = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    bus4.sub       = 1'b0;
    bus1.sub       = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready4", bus4.in_ready, 1'b1);
    check("rst_out_valid4", bus4.out_valid, 1'b0);
    check("rst_busy4", bus4.busy, 1'b0);
    check("rst_sum4", bus4.sum, 64'd0);
    check("rst_c_out4", bus4.c_out, 1'b0);
    check("rst_in_ready1", bus1.in_ready, 1'b1);
    check("rst_busy1", bus1.busy, 1'b0);

    // Carry from slice 0 into slice 1.
    accept4(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
    await4(5, 1'b1);
    handshake4();

    // Carry rippling through every slice.
    accept4(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b1);
    await4(5, 1'b1);
    handshake4();

`ifdef WIDE_ADD_SUB_EN
    accept4(64'd5, 64'd7, 1'b0, 1'b1, 1'b1);
    await4(5, 1'b1);
    handshake4();
    accept4(64'd7, 64'd5, 1'b0, 1'b1, 1'b1);
    await4(5, 1'b1);
    handshake4();
    accept4(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b1);
    await4(5, 1'b1);
    handshake4();
`endif

    // Backpressure with in_valid held high; operands change after the first acceptance.
    accept4(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n = 1;
    bus4.a    = 64'h0123_4567_89AB_CDEF;
    bus4.b    = 64'h1111_2222_3333_4444;
    bus4.c_in = 1'b1;
    check("busy_bp", bus4.busy, 1'b1);
    while (bus4.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency_bp", 64'(n), 64'd5);
    snap_sum = bus4.sum;
    snap_c   = bus4.c_out;
    pop_cmp4();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", bus4.out_valid, 1'b1);
      check("bp_sum_stable", bus4.sum, snap_sum);
      check("bp_c_out_stable", bus4.c_out, snap_c);
      check("bp_in_ready", bus4.in_ready, 1'b0);
    end
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    check("bp_idle_in_ready", bus4.in_ready, 1'b1);
    check("bp_idle_busy", bus4.busy, 1'b0);
    check("bp_idle_sum_kept", bus4.sum, snap_sum);
    // in_valid still high: second op is accepted on the coming edge.
    exp4_q.push_back(model4(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b1, 1'b0));
    await4(5, 1'b1);
    handshake4();

    // A few random additions.
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      accept4(ra, rb, rc, 1'b0, 1'b1);
      await4(5, 1'b1);
      handshake4();
    end

    // Reset while RUN is at idx=2 aborts the operation.
    accept4(64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", bus4.in_ready, 1'b1);
    check("abort_out_valid", bus4.out_valid, 1'b0);
    check("abort_busy", bus4.busy, 1'b0);
    check("abort_sum", bus4.sum, 64'd0);
    check("abort_c_out", bus4.c_out, 1'b0);
    repeat (6) @(negedge clk);
    check("abort_no_result", bus4.out_valid, 1'b0);

    // Single-slice instance.
    check("w1_in_ready", bus1.in_ready, 1'b1);
    bus1.a        = 16'hFFFF;
    bus1.b        = 16'h0001;
    bus1.c_in     = 1'b1;
    bus1.in_valid = 1'b1;
    exp1_q.push_back({1'b0, 16'hFFFF} + {1'b0, 16'h0001} + 17'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus1.in_valid = 1'b0;
        check("w1_busy", bus1.busy, 1'b1);
      end
    end while (bus1.out_valid !== 1'b1 && n < 40);
    check("w1_latency", 64'(n), 64'd2);
    check("w1_out_valid", bus1.out_valid, 1'b1);
    if (exp1_q.size() == 0) begin
      check("scoreboard1_nonempty", 64'd0, 64'd1);
    end else begin
      e1 = exp1_q.pop_front();
      check("w1_sum", bus1.sum, {48'b0, e1[15:0]});
      check("w1_c_out", bus1.c_out, {63'b0, e1[16]});
    end
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    check("w1_idle", bus1.in_ready, 1'b1);

    check("scoreboard4_drained", 64'(exp4_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
